// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a requester and data_mem_ctrl
//   req_valid/req_ready  request handshake
//   req_we               1 = write, 0 = read
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         zero-extend sub-word reads when 1
//   req_addr             byte address, little-endian
//   req_wdata            right-aligned write data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata/rsp_err    read data and reject flag, zero outside rsp_valid
interface data_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding byte/half/word data memory with configurable read latency
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  data_mem_ctrl_if slave: request handshake in, one-cycle response pulse out
//   DEPTH  memory depth in 32-bit words (power of 2)
//   RD_LAT read latency in cycles (1..4)
module data_mem_ctrl #(
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1
) (
   input logic            clk,
   input logic            rst,
   data_mem_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      state_q;
   logic [1:0]  cnt_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic        uns_q;
   logic [31:0] word_q;
   logic        valid_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [31:0] mem [DEPTH];
   logic          accept;
   logic          err;
   logic          wr;
   logic [AW-1:0] idx;
   logic [3:0]    be;
   logic [31:0]   wdata_rep;
   logic [31:0]   rd_word;
   logic [31:0]   rdata_d;
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] ln);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{ln, 3'b000} +: 8];
      h = ln[1] ? w[31:16] : w[15:0];
      return sz == 2'b00 ? {{24{~uns & b[7]}}, b} :
             sz == 2'b01 ? {{16{~uns & h[15]}}, h} : w;
   endfunction
   always_comb begin
      accept    = bus.req_valid && state_q == IDLE;
      idx       = bus.req_addr[AW+1:2];
      err       = bus.req_size == 2'b11 ||
                  (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                  {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH);
      wr        = accept && !err && bus.req_we;
      be        = bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
                  bus.req_size == 2'b01 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      // replicate sub-word data so the lane enables pick the right copy
      wdata_rep = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                  bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
      rd_word   = mem[idx];
      // RD_LAT = 1 extracts straight from the array on the acceptance edge
      rdata_d   = state_q == IDLE ?
                  extract(rd_word, bus.req_size, bus.req_unsigned, bus.req_addr[1:0]) :
                  extract(word_q, size_q, uns_q, lane_q);
   end
   // storage is never reset; a write commits on its acceptance edge
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (wr && be[i]) mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         size_q  <= 2'd0;
         lane_q  <= 2'd0;
         uns_q   <= 1'b0;
         word_q  <= 32'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= 32'd0;
               if (accept) begin
                  size_q <= bus.req_size;
                  lane_q <= bus.req_addr[1:0];
                  uns_q  <= bus.req_unsigned;
                  word_q <= rd_word;
                  if (err || bus.req_we) begin
                     state_q <= RESP;
                     valid_q <= 1'b1;
                     err_q   <= err;
                  end else if (RD_LAT == 1) begin
                     state_q <= RESP;
                     valid_q <= 1'b1;
                     rdata_q <= rdata_d;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= 2'(RD_LAT - 1);
                  end
               end
            end
            BUSY: begin
               if (cnt_q == 2'd1) begin
                  state_q <= RESP;
                  cnt_q   <= 2'd0;
                  valid_q <= 1'b1;
                  rdata_q <= rdata_d;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= 32'd0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.req_ready = state_q == IDLE;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_err   = err_q;
   assign bus.rsp_rdata = rdata_q;
endmodule
